id_operand_unit: RTL and testbench
==================================

// Module: id_operand_unit
// PURPOSE
//  Decode-stage operand unit: forwards GPR read data from MEM/WB write-back buses, extends
//  the 16-bit immediate, and evaluates the branch condition on forwarded operands.
//  Combinational results feed jump-PC logic the same cycle; a registered copy feeds ID/EX.
// PARAMETERS
//  none (all widths fixed: 32-bit data, 5-bit register index, 38-bit back-bus)
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   reset, synchronous, active-high
//  flush         in   1   drop current ID op (clears o_valid next edge)
//  rs            in   5   source register 1 index (instr[25:21])
//  rt            in   5   source register 2 index (instr[20:16])
//  rd1           in   32  GPR read data for rs
//  rd2           in   32  GPR read data for rt
//  imm16         in   16  immediate field (instr[15:0])
//  extop         in   1   0: extend into low half; 1: place imm16 in [31:16], low half 0
//  exsign        in   1   1: sign-extend, 0: zero-extend (ignored when extop=1)
//  branch_type   in   3   0 none,1 BEQ,2 BNE,3 BLEZ,4 BGTZ,5 BLTZ,6 BGEZ,7 none
//  mem_back      in   38  {regWrite[37], Wd[36:5], rw[4:0]} from MEM stage
//  wb_back       in   38  same format from WB stage
//  use_mem_back  in   1   enable forwarding from mem_back
//  use_wb_back   in   1   enable forwarding from wb_back
//  f_rd1         out  32  forwarded rs operand (combinational)
//  f_rd2         out  32  forwarded rt operand (combinational)
//  ext_out       out  32  extended immediate (combinational)
//  branch_avail  out  1   branch condition true (combinational)
//  o_rd1         out  32  registered f_rd1
//  o_rd2         out  32  registered f_rd2
//  o_ext         out  32  registered ext_out
//  o_valid       out  1   registered: op in ID/EX is live
// BEHAVIOUR
//  Forwarding (per operand, rs shown; rt identical with rd2):
//   - MEM hit: use_mem_back & mem_back[37] & mem_back[4:0]!=0 & mem_back[4:0]==rs
//   - WB hit:  use_wb_back  & wb_back[37]  & wb_back[4:0]!=0  & wb_back[4:0]==rs
//   - MEM hit -> mem_back[36:5]; else WB hit -> wb_back[36:5]; else rd1. MEM wins on tie.
//   - Register 0 never forwarded; f_rd=rd (GPR reads 0 for $0).
//  Extension:
//   - extop=1: {imm16,16'h0}; extop=0,exsign=1: {{16{imm16[15]}},imm16};
//     extop=0,exsign=0: {16'h0,imm16}.
//  Branch (signed two's-complement on f_rd1/f_rd2):
//   - BEQ f_rd1==f_rd2; BNE f_rd1!=f_rd2; BLEZ f_rd1<=0; BGTZ f_rd1>0;
//     BLTZ f_rd1<0; BGEZ f_rd1>=0; types 0 and 7 -> 0.
//  Combinational outputs: zero latency, no state dependency, valid during reset too.
//  Registers (posedge clk, priority rst > flush > load):
//   - rst: o_rd1=o_rd2=o_ext=0, o_valid=0.
//   - flush: o_valid<=0; o_rd1/o_rd2/o_ext hold previous values.
//   - else: o_rd1<=f_rd1, o_rd2<=f_rd2, o_ext<=ext_out, o_valid<=1.
//  Latency: 1 cycle from inputs to o_*; no handshake, no stall input (caller gates).
//  Reset asserted mid-stream clears registers at that edge; flush and rst together -> reset.
// TESTING
//  1 rs=5,rd1=1,mem_back={1,32'hAA,5},wb_back={1,32'hBB,5},both use=1 -> f_rd1=32'hAA;
//    use_mem_back=0 -> 32'hBB; mem regWrite=0 & wb regWrite=0 -> 32'h1.
//  2 rs=0, mem_back={1,32'hDEAD,0}, rd1=0 -> f_rd1=0 (no $0 forwarding).
//  3 imm16=16'h8001: extop0/exsign1 -> FFFF8001; exsign0 -> 00008001; extop1 -> 80010000.
//  4 branch: f_rd1=f_rd2=7 BEQ->1,BNE->0; f_rd1=32'hFFFFFFFF BLTZ->1,BLEZ->1,BGEZ->0,
//    BGTZ->0; f_rd1=0 BLEZ->1,BGEZ->1,BGTZ->0; type 7 -> 0.
//  5 branch via forward: rd1=0,rd2=3, wb_back={1,3,rs} BEQ -> branch_avail=1.
//  6 rst=1 one edge -> o_*=0,o_valid=0; load edge -> o_rd1=f_rd1,o_valid=1;
//    flush edge -> o_valid=0, o_rd1 unchanged; rst&flush same edge -> all zero.

Source files
------------

// File: rtl/id_operand_unit_if.sv
// Decode operand bus: GPR read data, immediate, back-buses in;
// forwarded operands, extension, branch flag and ID/EX copy out.
interface id_operand_unit_if;
  logic        flush;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [15:0] imm16;
  logic        extop;
  logic        exsign;
  logic [2:0]  branch_type;
  logic [37:0] mem_back;
  logic [37:0] wb_back;
  logic        use_mem_back;
  logic        use_wb_back;
  logic [31:0] f_rd1;
  logic [31:0] f_rd2;
  logic [31:0] ext_out;
  logic        branch_avail;
  logic [31:0] o_rd1;
  logic [31:0] o_rd2;
  logic [31:0] o_ext;
  logic        o_valid;

  modport master (
    output flush, rs, rt, rd1, rd2,
    output imm16, extop, exsign,
    output branch_type,
    output mem_back, wb_back,
    output use_mem_back, use_wb_back,
    input  f_rd1, f_rd2, ext_out,
    input  branch_avail,
    input  o_rd1, o_rd2, o_ext, o_valid
  );

  modport slave (
    input  flush, rs, rt, rd1, rd2,
    input  imm16, extop, exsign,
    input  branch_type,
    input  mem_back, wb_back,
    input  use_mem_back, use_wb_back,
    output f_rd1, f_rd2, ext_out,
    output branch_avail,
    output o_rd1, o_rd2, o_ext, o_valid
  );
endinterface

// File: rtl/id_operand_unit.sv
// Decode operand unit: MEM/WB forwarding, imm extension, branch test.
// Ports: clk, rst (sync, active-high), bus (id_operand_unit_if.slave).
module id_operand_unit (
  input  logic             clk,
  input  logic             rst,
  id_operand_unit_if.slave bus
);

  logic        mem_we;
  logic        wb_we;
  logic [4:0]  mem_rw;
  logic [4:0]  wb_rw;
  logic [31:0] mem_wd;
  logic [31:0] wb_wd;
  logic        mem_ok;
  logic        wb_ok;
  logic        mem_hit1;
  logic        mem_hit2;
  logic        wb_hit1;
  logic        wb_hit2;
  logic [31:0] f1;
  logic [31:0] f2;
  logic [31:0] ext;
  logic        br;

  assign mem_we = bus.mem_back[37];
  assign mem_wd = bus.mem_back[36:5];
  assign mem_rw = bus.mem_back[4:0];
  assign wb_we  = bus.wb_back[37];
  assign wb_wd  = bus.wb_back[36:5];
  assign wb_rw  = bus.wb_back[4:0];

  // $0 writes are never forwarded
  assign mem_ok = bus.use_mem_back
                & mem_we & (mem_rw != 5'd0);
  assign wb_ok  = bus.use_wb_back
                & wb_we & (wb_rw != 5'd0);

  assign mem_hit1 = mem_ok & (mem_rw == bus.rs);
  assign mem_hit2 = mem_ok & (mem_rw == bus.rt);
  assign wb_hit1  = wb_ok & (wb_rw == bus.rs);
  assign wb_hit2  = wb_ok & (wb_rw == bus.rt);

  // MEM is younger, so it wins over WB
  assign f1 = mem_hit1 ? mem_wd :
              wb_hit1  ? wb_wd  : bus.rd1;
  assign f2 = mem_hit2 ? mem_wd :
              wb_hit2  ? wb_wd  : bus.rd2;

  always_comb begin
    ext = {16'h0, bus.imm16};
    if (bus.extop)
      ext = {bus.imm16, 16'h0};
    else if (bus.exsign)
      ext = {{16{bus.imm16[15]}}, bus.imm16};
  end

  always_comb begin
    br = 1'b0;
    unique case (1'b1)
      (bus.branch_type == 3'd1):
        br = (f1 == f2);
      (bus.branch_type == 3'd2):
        br = (f1 != f2);
      (bus.branch_type == 3'd3):
        br = f1[31] | (f1 == 32'd0);
      (bus.branch_type == 3'd4):
        br = ~f1[31] & (f1 != 32'd0);
      (bus.branch_type == 3'd5):
        br = f1[31];
      (bus.branch_type == 3'd6):
        br = ~f1[31];
      default:
        br = 1'b0;
    endcase
  end

  assign bus.f_rd1        = f1;
  assign bus.f_rd2        = f2;
  assign bus.ext_out      = ext;
  assign bus.branch_avail = br;

  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_ext;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1   <= 32'd0;
      r_rd2   <= 32'd0;
      r_ext   <= 32'd0;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else begin
      r_rd1   <= f1;
      r_rd2   <= f2;
      r_ext   <= ext;
      r_valid <= 1'b1;
    end
  end

  assign bus.o_rd1   = r_rd1;
  assign bus.o_rd2   = r_rd2;
  assign bus.o_ext   = r_ext;
  assign bus.o_valid = r_valid;

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed bench for id_operand_unit: forwarding, extension,
// branch conditions and ID/EX register rst/flush/load behaviour.
module tb_id_operand_unit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  id_operand_unit_if bus ();

  id_operand_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  t,
    input logic        exp
  );
    bus.rd1 = a;
    bus.rd2 = b;
    bus.branch_type = t;
    #1;
    chk(tag, {31'd0, bus.branch_avail},
        {31'd0, exp});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.rs = 5'd0;
    bus.rt = 5'd0;
    bus.rd1 = 32'd0;
    bus.rd2 = 32'd0;
    bus.imm16 = 16'd0;
    bus.extop = 1'b0;
    bus.exsign = 1'b0;
    bus.branch_type = 3'd0;
    bus.mem_back = 38'd0;
    bus.wb_back = 38'd0;
    bus.use_mem_back = 1'b0;
    bus.use_wb_back = 1'b0;
    tick();

    // forwarding priority
    bus.rs = 5'd5;
    bus.rt = 5'd5;
    bus.rd1 = 32'h1;
    bus.rd2 = 32'h2;
    bus.mem_back = {1'b1, 32'hAA, 5'd5};
    bus.wb_back = {1'b1, 32'hBB, 5'd5};
    bus.use_mem_back = 1'b1;
    bus.use_wb_back = 1'b1;
    #1;
    chk("fwd_mem_rs", bus.f_rd1, 32'hAA);
    chk("fwd_mem_rt", bus.f_rd2, 32'hAA);
    bus.use_mem_back = 1'b0;
    #1;
    chk("fwd_wb_rs", bus.f_rd1, 32'hBB);
    chk("fwd_wb_rt", bus.f_rd2, 32'hBB);
    bus.use_mem_back = 1'b1;
    bus.mem_back = {1'b0, 32'hAA, 5'd5};
    bus.wb_back = {1'b0, 32'hBB, 5'd5};
    #1;
    chk("fwd_none_rs", bus.f_rd1, 32'h1);
    chk("fwd_none_rt", bus.f_rd2, 32'h2);
    bus.mem_back = {1'b1, 32'hAA, 5'd6};
    #1;
    chk("fwd_idx_miss", bus.f_rd1, 32'h1);

    // no $0 forwarding
    bus.rs = 5'd0;
    bus.rd1 = 32'd0;
    bus.mem_back = {1'b1, 32'hDEAD, 5'd0};
    bus.wb_back = {1'b1, 32'hBEEF, 5'd0};
    #1;
    chk("fwd_r0", bus.f_rd1, 32'd0);

    // extension
    bus.imm16 = 16'h8001;
    bus.extop = 1'b0;
    bus.exsign = 1'b1;
    #1;
    chk("ext_sign", bus.ext_out, 32'hFFFF8001);
    bus.exsign = 1'b0;
    #1;
    chk("ext_zero", bus.ext_out, 32'h00008001);
    bus.extop = 1'b1;
    bus.exsign = 1'b1;
    #1;
    chk("ext_lui", bus.ext_out, 32'h80010000);
    bus.extop = 1'b0;
    bus.imm16 = 16'h7FFF;
    #1;
    chk("ext_sign_pos", bus.ext_out, 32'h00007FFF);

    // branch on plain operands
    bus.use_mem_back = 1'b0;
    bus.use_wb_back = 1'b0;
    bus.rs = 5'd1;
    bus.rt = 5'd2;
    br("beq_eq", 32'd7, 32'd7, 3'd1, 1'b1);
    br("bne_eq", 32'd7, 32'd7, 3'd2, 1'b0);
    br("beq_ne", 32'd7, 32'd8, 3'd1, 1'b0);
    br("bne_ne", 32'd7, 32'd8, 3'd2, 1'b1);
    br("bltz_m1", 32'hFFFFFFFF, 0, 3'd5, 1'b1);
    br("blez_m1", 32'hFFFFFFFF, 0, 3'd3, 1'b1);
    br("bgez_m1", 32'hFFFFFFFF, 0, 3'd6, 1'b0);
    br("bgtz_m1", 32'hFFFFFFFF, 0, 3'd4, 1'b0);
    br("blez_0", 32'd0, 32'd0, 3'd3, 1'b1);
    br("bgez_0", 32'd0, 32'd0, 3'd6, 1'b1);
    br("bgtz_0", 32'd0, 32'd0, 3'd4, 1'b0);
    br("bltz_0", 32'd0, 32'd0, 3'd5, 1'b0);
    br("bgtz_1", 32'd1, 32'd0, 3'd4, 1'b1);
    br("blez_1", 32'd1, 32'd0, 3'd3, 1'b0);
    br("bltz_min", 32'h80000000, 0, 3'd5, 1'b1);
    br("bgtz_max", 32'h7FFFFFFF, 0, 3'd4, 1'b1);
    br("type7", 32'd7, 32'd7, 3'd7, 1'b0);
    br("type0", 32'd7, 32'd7, 3'd0, 1'b0);

    // branch through forwarded operand
    bus.rs = 5'd3;
    bus.rt = 5'd4;
    bus.use_wb_back = 1'b1;
    bus.wb_back = {1'b1, 32'd3, 5'd3};
    br("beq_fwd", 32'd0, 32'd3, 3'd1, 1'b1);
    chk("beq_fwd_op", bus.f_rd1, 32'd3);
    bus.use_wb_back = 1'b0;
    br("beq_nofwd", 32'd0, 32'd3, 3'd1, 1'b0);

    // registers: reset
    bus.rs = 5'd1;
    bus.rt = 5'd2;
    bus.rd1 = 32'h1234;
    bus.rd2 = 32'h5678;
    bus.imm16 = 16'hFFFE;
    bus.extop = 1'b0;
    bus.exsign = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_rd1", bus.o_rd1, 32'd0);
    chk("rst_rd2", bus.o_rd2, 32'd0);
    chk("rst_ext", bus.o_ext, 32'd0);
    chk("rst_valid", {31'd0, bus.o_valid}, 0);
    chk("rst_comb", bus.f_rd1, 32'h1234);

    // load
    rst = 1'b0;
    tick();
    chk("ld_rd1", bus.o_rd1, 32'h1234);
    chk("ld_rd2", bus.o_rd2, 32'h5678);
    chk("ld_ext", bus.o_ext, 32'hFFFFFFFE);
    chk("ld_valid", {31'd0, bus.o_valid}, 1);

    // flush holds data
    bus.rd1 = 32'hCAFE;
    bus.imm16 = 16'h0010;
    bus.flush = 1'b1;
    tick();
    chk("fl_valid", {31'd0, bus.o_valid}, 0);
    chk("fl_rd1", bus.o_rd1, 32'h1234);
    chk("fl_ext", bus.o_ext, 32'hFFFFFFFE);

    bus.flush = 1'b0;
    tick();
    chk("ld2_rd1", bus.o_rd1, 32'hCAFE);
    chk("ld2_ext", bus.o_ext, 32'h00000010);
    chk("ld2_valid", {31'd0, bus.o_valid}, 1);

    // rst beats flush
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    chk("rf_rd1", bus.o_rd1, 32'd0);
    chk("rf_rd2", bus.o_rd2, 32'd0);
    chk("rf_ext", bus.o_ext, 32'd0);
    chk("rf_valid", {31'd0, bus.o_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
